pipe_stage: RTL



---
 rtl/pipe_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_stage.sv
// pipe_stage: parametrised inter-stage pipeline buffer.
// A DEPTH-entry skid FIFO sits between two pipeline stages and uses a valid/ready
// handshake on each side. It supports synchronous flush (branch/jump kill) and
// hazard bubble insertion (the head is hidden and held). It also keeps a
// saturating count of the cycles in which the stage stalled.
module pipe_stage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_vld,
  output logic                       o_rdy,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_vld,
  input  logic                       i_rdy,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_flush,
  input  logic                       i_bubble,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [CNT_W-1:0]           o_stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // Saturating increment: once the counter reaches all-ones it holds there and
  // never wraps to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Registered state. Storage holds opaque payload and is not reset.
  logic [WIDTH-1:0] mem_p1 [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [OCC_W-1:0] count_p1;
  logic [CNT_W-1:0] stall_cnt_p1;

  // Per-cycle handshake decisions.
  logic             full_p0;
  logic             empty_p0;
  logic             rdy_p0;
  logic             vld_p0;
  logic             push_p0;
  logic             pop_p0;
  logic             stall_p0;

  // Next-state values for the control registers.
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [OCC_W-1:0] count_nxt;

  // Handshake: ready depends only on the current occupancy. A pop in the same
  // cycle does not free space, so ready never depends on the downstream ready.
  always_comb begin
    full_p0  = (count_p1 == OCC_FULL);
    empty_p0 = (count_p1 == '0);
    rdy_p0   = !full_p0 && !i_flush;
    vld_p0   = !empty_p0 && !i_bubble && !i_flush;
    push_p0  = i_vld && rdy_p0;
    pop_p0   = vld_p0 && i_rdy;
    stall_p0 = !empty_p0 && !i_flush && (i_bubble || !i_rdy);
  end

  // Pointer and occupancy next-state. A flush kills everything and takes
  // priority over push and pop.
  always_comb begin
    wr_ptr_nxt = wr_ptr_p1;
    rd_ptr_nxt = rd_ptr_p1;
    count_nxt  = count_p1;
    if (i_flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push_p0) wr_ptr_nxt = wr_ptr_p1 + PTR_W'(1);
      if (pop_p0)  rd_ptr_nxt = rd_ptr_p1 + PTR_W'(1);
      case ({push_p0, pop_p0})
        2'b10:   count_nxt = count_p1 + OCC_W'(1);
        2'b01:   count_nxt = count_p1 - OCC_W'(1);
        default: count_nxt = count_p1;
      endcase
    end
  end

  // Control registers: asynchronous clear, so all buffered payloads are discarded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      wr_ptr_p1 <= wr_ptr_nxt;
      rd_ptr_p1 <= rd_ptr_nxt;
      count_p1  <= count_nxt;
    end
  end

  // Payload storage: write the accepted input into the slot at the write pointer.
  always_ff @(posedge i_clk) begin
    if (push_p0) mem_p1[wr_ptr_p1] <= i_data;
  end

  // Stall counter: counts cycles in which a held head was not consumed.
  // It clears only on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_p1 <= '0;
    end else if (stall_p0) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  // Outputs: the head is shown on o_data whenever the buffer is occupied.
  // A bubble affects only o_vld.
  assign o_rdy       = rdy_p0;
  assign o_vld       = vld_p0;
  assign o_data      = empty_p0 ? '0 : mem_p1[rd_ptr_p1];
  assign o_count     = count_p1;
  assign o_full      = full_p0;
  assign o_empty     = empty_p0;
  assign o_stall_cnt = stall_cnt_p1;

endmodule
